// File: rtl/alu_seq.sv
// Handshaked integer ALU: single-cycle base ops, iterative RV32M multiply/divide.
// Result, zero, carry and div0 are registered and held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             div0
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [2:0]         fn;
    // neg_lo: sign of product or quotient; neg_hi: sign of remainder
    logic               neg_lo;
    logic               neg_hi;

    logic [WIDTH-1:0]   base_res;
    logic               base_carry;
    logic [WIDTH:0]     add_w;
    logic [SHW-1:0]     shamt;

    always_comb begin
        shamt      = b[SHW-1:0];
        add_w      = {1'b0, a} + {1'b0, b};
        base_res   = '0;
        base_carry = 1'b0;
        case (op[3:0])
            4'b0000: begin
                base_res   = add_w[WIDTH-1:0];
                base_carry = add_w[WIDTH];
            end
            4'b1000: begin
                base_res   = a - b;
                base_carry = (a < b);
            end
            4'b0111: base_res = a & b;
            4'b0110: base_res = a | b;
            4'b0100: base_res = a ^ b;
            4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: base_res = {{(WIDTH-1){1'b0}}, a < b};
            4'b0001: base_res = a << shamt;
            4'b0101: base_res = a >> shamt;
            4'b1101: base_res = $signed(a) >>> shamt;
            default: ;
        endcase
    end

    logic             is_div_in;
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_by0;
    logic             div_ovf;
    logic [WIDTH-1:0] spec_res;

    // The iterative core works on magnitudes; signs are reapplied on completion.
    always_comb begin
        is_div_in = op[2];
        a_sgn     = is_div_in ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        b_sgn     = is_div_in ? ~op[0] : (op[1:0] == 2'b01);
        a_neg     = a_sgn & a[WIDTH-1];
        b_neg     = b_sgn & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div_by0   = is_div_in && (b == '0);
        div_ovf   = is_div_in && ~op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        if (div_by0)
            spec_res = op[1] ? a : '1;
        else
            spec_res = op[1] ? '0 : a;
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   m_res;

    // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = rem_sh - {1'b0, mcand};
        if (fn[2]) begin
            if (div_diff[WIDTH])
                acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = {mul_sum, acc[WIDTH-1:1]};
        end
        prod = neg_lo ? -acc_nx : acc_nx;
        quo  = neg_lo ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
        rem  = neg_hi ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
        case (fn)
            3'b000:         m_res = prod[WIDTH-1:0];
            3'b100, 3'b101: m_res = quo;
            3'b110, 3'b111: m_res = rem;
            default:        m_res = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            div0      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            fn        <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    if (!op[4]) begin
                        result    <= base_res;
                        zero      <= (base_res == '0);
                        carry     <= base_carry;
                        div0      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (div_by0 || div_ovf) begin
                        result    <= spec_res;
                        zero      <= (spec_res == '0);
                        carry     <= 1'b0;
                        div0      <= div_by0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        fn     <= op[2:0];
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        mcand  <= b_mag;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        result    <= m_res;
                        zero      <= (m_res == '0);
                        carry     <= 1'b0;
                        div0      <= 1'b0;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It executes the base integer ops in one registered cycle and the RV32M multiply/divide/remainder ops iteratively over WIDTH cycles. It has valid/ready on both input and output so the execute stage can stall around it. Result flags are zero, carry and a divide-by-zero indicator.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, minimum 8
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept an op this cycle
a  input  WIDTH  operand A (rs1)
b  input  WIDTH  operand B (rs2/imm)
op  input  5  op[4]=0: base op, op[3:0] is the base ALU code; op[4]=1: M op, op[2:0] is funct3
kill  input  1  synchronous abort of any op in flight
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  WIDTH  result
zero  output  1  result == 0
carry  output  1  ADD: carry-out; SUB: unsigned borrow (a<b); other ops: 0
div0  output  1  high with DIV/DIVU/REM/REMU result when b == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; carry=0; div0=0; iteration counter=0.
- FSM states IDLE, BUSY, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready; a, b and op are captured on accept.
- Base op accepted: IDLE->DONE; out_valid high the next cycle (latency 1).
- Base op codes:
  - 0000 ADD; 1000 SUB; 0111 AND; 0110 OR; 0100 XOR.
  - 0010 SLT (signed); 0011 SLTU.
  - 0001 SLL; 0101 SRL; 1101 SRA. Shift amount is b[SHW-1:0].
  - Any other base code: result 0, carry 0.
- M op accepted: IDLE->BUSY. Counter runs WIDTH cycles, then BUSY->DONE. out_valid rises exactly WIDTH+1 cycles after accept.
- M op funct3:
  - 000 MUL: low WIDTH bits of a*b.
  - 001 MULH: signed x signed, high half.
  - 010 MULHSU: a signed x b unsigned, high half.
  - 011 MULHU: unsigned x unsigned, high half.
  - 100 DIV, 101 DIVU: quotient. 110 REM, 111 REMU: remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
- Divide special cases skip BUSY and complete with latency 1:
  - b==0: quotient all ones; remainder = a; div0=1.
  - Signed overflow (a = most negative value, b = all ones): quotient = a; remainder = 0; div0=0.
- DONE: result, zero, carry and div0 stay stable while out_valid=1 and out_ready=0. When out_ready=1: DONE->IDLE, and out_valid drops the next cycle. A new op is not accepted in the same cycle as the DONE handshake.
- kill=1 in any state: next state IDLE, out_valid=0, counter cleared, result registers unchanged. kill in the same cycle as an accept drops that accept.
- rst_n asserted mid-operation: immediate return to reset values; no result is emitted.
- Operand inputs are don't-care outside accept cycles. Flags describe only the currently held result.

Test Plan:
- Base ops, WIDTH=32:
  - ADD a=0xFFFFFFFF, b=1 -> one cycle after accept result=0, zero=1, carry=1.
  - SUB a=3, b=5 -> result=0xFFFFFFFE, carry=1, zero=0.
  - SRA a=0x80000000, b=0x24 (shift by 4) -> result=0xF8000000.
- Multiply, WIDTH=32:
  - MULH a=0xFFFFFFFF (-1), b=2 -> result=0xFFFFFFFF; out_valid exactly 33 cycles after accept.
  - MULHU with the same operands -> result=1.
  - MUL 7*6 -> result=42.
- Divide: DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
- Divide special cases:
  - DIVU b=0, a=0x1234 -> result=0xFFFFFFFF, div0=1, latency 1.
  - REM b=0 -> result=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, div0=0.
- Backpressure: complete an ADD with out_ready held low for 5 cycles -> out_valid and result stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Abort and reset:
  - kill at BUSY cycle 10 of a DIV -> out_valid never rises, in_ready=1 next cycle; a following ADD 2+2 -> 4.
  - rst_n low mid-MUL -> all outputs at reset values immediately.
